// File: rtl/perf_event_counter_bank_if.sv
// Bus bundle for perf_event_counter_bank.
// Ports (slave view):
//   evt_i     per-channel event pulses
//   stall_i   global stall, qualifies channels selected by GATE_MASK
//   halt_i    processor halt
//   clr_i     synchronous clear of all counters
//   rd_sel_i  read index (NUM_EVT selects the cycle counter)
//   rd_data_o registered read data
//   sat_o     sticky saturation flags (bit NUM_EVT = cycle counter)
//   frozen_o  counting stopped (halted or watchdog)
//   timeout_o watchdog tripped
interface perf_event_counter_bank_if #(
    parameter int NUM_EVT = 8,
    parameter int CNT_W   = 32
);
    localparam int SEL_W = $clog2(NUM_EVT + 1);

    logic [NUM_EVT-1:0] evt_i;
    logic               stall_i;
    logic               halt_i;
    logic               clr_i;
    logic [SEL_W-1:0]   rd_sel_i;
    logic [CNT_W-1:0]   rd_data_o;
    logic [NUM_EVT:0]   sat_o;
    logic               frozen_o;
    logic               timeout_o;

    modport master (
        output evt_i, stall_i, halt_i, clr_i, rd_sel_i,
        input  rd_data_o, sat_o, frozen_o, timeout_o
    );

    modport slave (
        input  evt_i, stall_i, halt_i, clr_i, rd_sel_i,
        output rd_data_o, sat_o, frozen_o, timeout_o
    );
endinterface

// File: rtl/perf_event_counter_bank.sv
// Performance-monitor counter bank: one free-running cycle counter plus
// NUM_EVT event counters, optionally stall-qualified per channel. Counting
// freezes on processor halt or when the cycle watchdog trips; counters
// saturate at all-ones with a sticky flag. Counters are read through a
// registered port that returns the pre-update value of the selected counter.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    perf_event_counter_bank_if slave (events, control, read port, status)
//
// state      | meaning
// ST_RUN     | counting cycles and qualified events
// ST_HALTED  | frozen by halt_i, leaves only via clr_i or reset
// ST_TIMEOUT | frozen by the cycle watchdog, leaves only via clr_i or reset
module perf_event_counter_bank #(
    parameter int          NUM_EVT   = 8,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] GATE_MASK = 16'h00F0,
    parameter int unsigned CYC_LIMIT = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    perf_event_counter_bank_if.slave    bus
);
    localparam int SEL_W = $clog2(NUM_EVT + 1);
    localparam int CYC   = NUM_EVT;   // index of the cycle counter
    // Watchdog limit truncated to the counter width; trip when the counter
    // is one below it and about to increment.
    localparam logic [CNT_W-1:0] LIMIT_T  = CNT_W'(CYC_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = LIMIT_T - CNT_W'(1);

    typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_TIMEOUT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_EVT+1];
    logic [CNT_W-1:0] cnt_d [NUM_EVT+1];
    logic [NUM_EVT:0] sat_q, sat_d;
    logic [NUM_EVT:0] inc;
    logic [CNT_W-1:0] rd_data_q, rd_mux;
    logic             wd_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            sat_q     <= '0;
            rd_data_q <= '0;
            for (int i = 0; i <= NUM_EVT; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            sat_q     <= sat_d;
            rd_data_q <= rd_mux;
            for (int i = 0; i <= NUM_EVT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_EVT; i++)
            inc[i] = bus.evt_i[i] && !(GATE_MASK[i] && bus.stall_i);
        inc[CYC] = 1'b1;
    end

    // A saturated cycle counter no longer increments, so it cannot trip.
    assign wd_hit = (CYC_LIMIT != 0) && (cnt_q[CYC] == LIMIT_M1) && (cnt_q[CYC] != '1);

    always_comb begin
        state_d = state_q;
        sat_d   = sat_q;
        for (int i = 0; i <= NUM_EVT; i++) cnt_d[i] = cnt_q[i];

        if (bus.clr_i) begin
            state_d = ST_RUN;
            sat_d   = '0;
            for (int i = 0; i <= NUM_EVT; i++) cnt_d[i] = '0;
        end else if (state_q == ST_RUN) begin
            for (int i = 0; i <= NUM_EVT; i++) begin
                if (inc[i]) begin
                    if (cnt_q[i] == '1) sat_d[i] = 1'b1;
                    else                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // Halt takes precedence over a simultaneous watchdog trip.
            if (bus.halt_i)  state_d = ST_HALTED;
            else if (wd_hit) state_d = ST_TIMEOUT;
        end
    end

    // Read mux works on pre-update values; out-of-range indices return 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i <= NUM_EVT; i++)
            if (bus.rd_sel_i == SEL_W'(i)) rd_mux = cnt_q[i];
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.sat_o     = sat_q;
    assign bus.frozen_o  = (state_q != ST_RUN);
    assign bus.timeout_o = (state_q == ST_TIMEOUT);
endmodule

// File: tb/tb_perf_event_counter_bank.sv
module tb_perf_event_counter_bank;
    logic clk = 1'b0;
    logic rst_n;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    // a: default build; b: 8-bit counters, watchdog off; c: 16-bit, watchdog at 16
    perf_event_counter_bank_if #(.NUM_EVT(8), .CNT_W(32)) a_if ();
    perf_event_counter_bank_if #(.NUM_EVT(8), .CNT_W(8))  b_if ();
    perf_event_counter_bank_if #(.NUM_EVT(8), .CNT_W(16)) c_if ();

    perf_event_counter_bank #(.NUM_EVT(8), .CNT_W(32), .GATE_MASK(16'h00F0), .CYC_LIMIT(100000))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    perf_event_counter_bank #(.NUM_EVT(8), .CNT_W(8), .GATE_MASK(16'h00F0), .CYC_LIMIT(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    perf_event_counter_bank #(.NUM_EVT(8), .CNT_W(16), .GATE_MASK(16'h00F0), .CYC_LIMIT(16))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_if.evt_i = '0; a_if.stall_i = 0; a_if.halt_i = 0; a_if.clr_i = 0; a_if.rd_sel_i = '0;
        b_if.evt_i = '0; b_if.stall_i = 0; b_if.halt_i = 0; b_if.clr_i = 0; b_if.rd_sel_i = '0;
        c_if.evt_i = '0; c_if.stall_i = 0; c_if.halt_i = 0; c_if.clr_i = 0; c_if.rd_sel_i = '0;
        tick(3);
        chk("rst_frozen",  a_if.frozen_o,  0);
        chk("rst_timeout", a_if.timeout_o, 0);
        chk("rst_rd_data", a_if.rd_data_o, 0);
        chk("rst_sat",     a_if.sat_o,     0);

        // 1: ch0 counts 10 events
        rst_n = 1'b1; a_if.evt_i = 8'h01; a_if.rd_sel_i = 4'd0;
        tick(10);
        a_if.evt_i = '0;
        tick(1);
        chk("t1_ch0", a_if.rd_data_o, 10);
        a_if.rd_sel_i = 4'd8;
        tick(1);
        chk("t1_cycle", a_if.rd_data_o, 11);
        a_if.rd_sel_i = 4'd11;
        tick(1);
        chk("t1_sel_oob", a_if.rd_data_o, 0);

        // 2: gated ch4 vs ungated ch0, stall in 3 of 8 cycles
        a_if.clr_i = 1; tick(1); a_if.clr_i = 0;
        for (int k = 0; k < 8; k++) begin
            a_if.evt_i   = 8'h11;
            a_if.stall_i = (k == 2 || k == 4 || k == 6);
            tick(1);
        end
        a_if.evt_i = '0; a_if.stall_i = 0; a_if.halt_i = 1;
        tick(1);
        a_if.halt_i = 0;
        chk("t2_frozen", a_if.frozen_o, 1);
        a_if.rd_sel_i = 4'd4; tick(1);
        chk("t2_ch4_gated", a_if.rd_data_o, 5);
        a_if.rd_sel_i = 4'd0; tick(1);
        chk("t2_ch0_ungated", a_if.rd_data_o, 8);
        a_if.rd_sel_i = 4'd8; tick(1);
        chk("t2_cycle", a_if.rd_data_o, 9);

        // 3: halt on 20th cycle with evt1, then frozen 50 cycles
        a_if.clr_i = 1; tick(1); a_if.clr_i = 0;
        for (int k = 0; k < 20; k++) begin
            a_if.evt_i  = 8'h02;
            a_if.halt_i = (k == 19);
            tick(1);
        end
        a_if.halt_i = 0;
        tick(50);
        chk("t3_frozen",  a_if.frozen_o,  1);
        chk("t3_timeout", a_if.timeout_o, 0);
        a_if.rd_sel_i = 4'd1; tick(1);
        chk("t3_ch1", a_if.rd_data_o, 20);
        a_if.rd_sel_i = 4'd8; tick(1);
        chk("t3_cycle", a_if.rd_data_o, 20);
        a_if.evt_i = '0;

        // 6: clear and halt together
        a_if.clr_i = 1; a_if.halt_i = 1; tick(1);
        a_if.clr_i = 0; a_if.halt_i = 0;
        chk("t6_frozen", a_if.frozen_o, 0);
        a_if.rd_sel_i = 4'd8; tick(1);
        chk("t6_cycle_zero", a_if.rd_data_o, 0);
        a_if.rd_sel_i = 4'd1; tick(1);
        chk("t6_ch1_zero", a_if.rd_data_o, 0);
        a_if.rd_sel_i = 4'd11; tick(1);
        chk("t6_sel_oob", a_if.rd_data_o, 0);
        chk("t6_sat", a_if.sat_o, 0);

        // 4: saturation on 8-bit bank
        b_if.clr_i = 1; tick(1); b_if.clr_i = 0;
        b_if.evt_i = 8'h04;
        tick(300);
        b_if.evt_i = '0; b_if.halt_i = 1; tick(1); b_if.halt_i = 0;
        b_if.rd_sel_i = 4'd2; tick(1);
        chk("t4_ch2_sat", b_if.rd_data_o, 8'hFF);
        chk("t4_sat_flags", b_if.sat_o, 9'h104);
        b_if.rd_sel_i = 4'd8; tick(1);
        chk("t4_cycle_sat", b_if.rd_data_o, 8'hFF);
        chk("t4_no_timeout", b_if.timeout_o, 0);
        b_if.clr_i = 1; tick(1); b_if.clr_i = 0;
        chk("t4_clr_sat", b_if.sat_o, 0);
        chk("t4_clr_frozen", b_if.frozen_o, 0);
        b_if.rd_sel_i = 4'd2; tick(1);
        chk("t4_clr_ch2", b_if.rd_data_o, 0);

        // 5: watchdog at 16
        c_if.clr_i = 1; tick(1); c_if.clr_i = 0;
        tick(15);
        chk("t5_pre_timeout", c_if.timeout_o, 0);
        tick(1);
        chk("t5_timeout", c_if.timeout_o, 1);
        chk("t5_frozen",  c_if.frozen_o,  1);
        c_if.halt_i = 1; tick(1); c_if.halt_i = 0;
        chk("t5_halt_ignored", c_if.timeout_o, 1);
        c_if.rd_sel_i = 4'd8; tick(1);
        chk("t5_cycle", c_if.rd_data_o, 16);

        // halt coincident with watchdog trip: halt wins
        c_if.clr_i = 1; tick(1); c_if.clr_i = 0;
        chk("t5b_clr_timeout", c_if.timeout_o, 0);
        tick(15);
        c_if.halt_i = 1; tick(1); c_if.halt_i = 0;
        chk("t5b_frozen",  c_if.frozen_o,  1);
        chk("t5b_timeout", c_if.timeout_o, 0);
        tick(1);
        chk("t5b_cycle", c_if.rd_data_o, 16);

        // reset mid-operation
        a_if.evt_i = 8'h01; tick(5);
        rst_n = 1'b0; tick(1);
        chk("rst2_a_rd", a_if.rd_data_o, 0);
        chk("rst2_c_frozen", c_if.frozen_o, 0);
        chk("rst2_c_timeout", c_if.timeout_o, 0);
        rst_n = 1'b1; a_if.evt_i = '0; a_if.rd_sel_i = 4'd0;
        tick(1);
        chk("rst2_a_ch0", a_if.rd_data_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
